// File: rtl/roi_fetch_ctrl.sv
// roi_fetch_ctrl: waits for a complete camera frame, then streams an OUT_DIM x OUT_DIM
// subsampled region of interest out of the frame buffer with ready/valid backpressure.
module roi_fetch_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int OUT_DIM     = 28,
    parameter int STEP        = 10,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        start,
    input  logic        capture_end,
    input  logic [9:0]  box_left,
    input  logic [9:0]  box_up,
    output logic        cap_en,
    output logic [18:0] fb_raddr,
    input  logic [7:0]  fb_rdata,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [9:0]  out_idx,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, ARM, WAIT_FRAME, READ, FLUSH, DONE} state_t;

    localparam int NS = OUT_DIM * OUT_DIM;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int XW = $clog2(OUT_DIM + 1);

    state_t         state, nxt;
    logic [TW-1:0]  tcnt;
    logic [XW-1:0]  x;
    logic [9:0]     idx;
    logic [18:0]    col, row_base, left_q, raddr_q;
    logic           err_q, issue, in_range, waiting, timeout, last_col, last_smp;

    assign in_range = (32'(box_left) + 32'((OUT_DIM - 1) * STEP) < 32'(H_ACTIVE)) &&
                      (32'(box_up) + 32'((OUT_DIM - 1) * STEP) < 32'(V_ACTIVE));
    assign waiting  = state == ARM || state == WAIT_FRAME;
    assign timeout  = tcnt == TW'(TIMEOUT_CYC - 1);
    assign last_col = x == XW'(OUT_DIM - 1);
    assign last_smp = idx == 10'(NS - 1);

    always_ff @(posedge pclk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    // A frame arriving on the timeout cycle still wins over the timeout.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:       nxt = start && in_range ? ARM : IDLE;
            ARM:        nxt = capture_end ? WAIT_FRAME : timeout ? IDLE : ARM;
            WAIT_FRAME: nxt = capture_end ? READ : timeout ? IDLE : WAIT_FRAME;
            READ:       nxt = issue && last_smp ? FLUSH : READ;
            FLUSH:      nxt = DONE;
            DONE:       nxt = IDLE;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        cap_en   = !(state == READ || state == FLUSH || (state == WAIT_FRAME && capture_end));
        busy     = state != IDLE;
        done     = state == DONE;
        err      = err_q;
        issue    = state == READ && out_ready;
        fb_raddr = issue ? row_base + col : raddr_q;
        out_data = out_valid ? fb_rdata : 8'd0;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            err_q     <= 1'b0;
            tcnt      <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            raddr_q   <= '0;
            idx       <= '0;
            x         <= '0;
            col       <= '0;
            row_base  <= '0;
            left_q    <= '0;
        end else begin
            err_q     <= (state == IDLE && start && !in_range) || (waiting && !capture_end && timeout);
            tcnt      <= waiting ? tcnt + 1'b1 : '0;
            out_valid <= issue;
            if (state == IDLE && start) begin
                left_q   <= 19'(box_left);
                col      <= 19'(box_left);
                row_base <= 19'(32'(box_up) * 32'(H_ACTIVE));
                x        <= '0;
                idx      <= '0;
            end
            if (issue) begin
                out_idx  <= idx;
                raddr_q  <= fb_raddr;
                idx      <= idx + 1'b1;
                x        <= last_col ? '0 : x + 1'b1;
                col      <= last_col ? left_q : col + 19'(STEP);
                row_base <= last_col ? row_base + 19'(STEP * H_ACTIVE) : row_base;
            end
        end
    end
endmodule

// File: tb/tb_roi_fetch_ctrl.sv
// tb_roi_fetch_ctrl: scoreboard bench; stimulus queues expected samples, a monitor checks the stream.
module tb_roi_fetch_ctrl;
    logic        pclk = 0, rst = 1, start = 0, capture_end = 0, out_ready = 0;
    logic [9:0]  box_left = 0, box_up = 0;
    logic        cap_en, out_valid, busy, done, err;
    logic [18:0] fb_raddr;
    logic [7:0]  fb_rdata = 0, out_data;
    logic [9:0]  out_idx;

    typedef struct {int idx; int addr;} exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0;
    int nseen = 0, done_cnt = 0, err_cnt = 0;
    int addr0 = -1, addr1 = -1, addr28 = -1;
    int prev_addr = 0;
    logic prev_ready = 0, prev_valid = 0;

    roi_fetch_ctrl #(.TIMEOUT_CYC(100)) dut (
        .pclk(pclk), .rst(rst), .start(start), .capture_end(capture_end),
        .box_left(box_left), .box_up(box_up), .cap_en(cap_en), .fb_raddr(fb_raddr),
        .fb_rdata(fb_rdata), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 pclk = ~pclk;

    function automatic logic [7:0] mem(input int a);
        return 8'(a ^ (a >> 7) ^ (a >> 13));
    endfunction

    always @(posedge pclk) fb_rdata <= mem(int'(fb_raddr));

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push_fetch(input int bl, input int bu);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                exp_q.push_back('{r * 28 + c, (bu + r * 10) * 640 + bl + c * 10});
    endtask

    task automatic pulse_start(input int bl, input int bu);
        box_left = 10'(bl);
        box_up = 10'(bu);
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic cap_pulse(input logic exp_cap, input string nm);
        capture_end = 1;
        @(negedge pclk);
        check(nm, cap_en, exp_cap);
        tick();
        capture_end = 0;
    endtask

    task automatic wait_done(input int budget, input logic toggle);
        int n = 0;
        logic got = 0;
        while (!got && n < budget) begin
            @(negedge pclk);
            if (done) got = 1;
            tick();
            if (toggle) out_ready = ~out_ready;
            n++;
        end
        check("done_seen", got, 1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_idx", int'(out_idx), e.idx);
                    check("issued_addr", prev_addr, e.addr);
                    check("out_data", int'(out_data), int'(mem(e.addr)));
                    check("valid_after_issue", prev_ready, 1);
                    check("cap_en_read", cap_en, 0);
                end
                if (out_idx == 0) addr0 = prev_addr;
                if (out_idx == 1) addr1 = prev_addr;
                if (out_idx == 28) addr28 = prev_addr;
                nseen++;
            end
            if (done) begin
                done_cnt++;
                check("done_after_last", prev_valid, 1);
                check("done_queue_empty", exp_q.size(), 0);
                check("done_cap_en", cap_en, 1);
            end
            if (err) err_cnt++;
            prev_addr = int'(fb_raddr);
            prev_ready = out_ready;
            prev_valid = out_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) tick();
        @(negedge pclk);
        check("rst_cap_en", cap_en, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", out_valid, 0);
        check("rst_raddr", int'(fb_raddr), 0);
        check("rst_idx", int'(out_idx), 0);
        check("rst_data", int'(out_data), 0);
        tick();
        rst = 0;
        tick();

        // nominal fetch
        push_fetch(180, 100);
        out_ready = 1;
        pulse_start(180, 100);
        @(negedge pclk);
        check("arm_busy", busy, 1);
        check("arm_cap_en", cap_en, 1);
        tick();
        cap_pulse(1, "cap_en_wait");
        tick();
        cap_pulse(0, "cap_en_drop");
        wait_done(1000, 0);
        check("addr0", addr0, 64180);
        check("addr1", addr1, 64190);
        check("addr28", addr28, 70580);
        check("nominal_count", nseen, 784);

        // backpressure, box at the last legal position
        nseen = 0;
        push_fetch(369, 209);
        pulse_start(369, 209);
        cap_pulse(1, "bp_cap_wait");
        cap_pulse(0, "bp_cap_drop");
        out_ready = 1;
        wait_done(3000, 1);
        check("bp_count", nseen, 784);
        out_ready = 0;
        tick();

        // range rejects
        pulse_start(400, 0);
        @(negedge pclk);
        check("rej_err", err, 1);
        check("rej_busy", busy, 0);
        check("rej_raddr", int'(fb_raddr), 307199);
        tick();
        @(negedge pclk);
        check("rej_err_pulse", err, 0);
        check("rej_idle", busy, 0);
        tick();
        pulse_start(0, 210);
        @(negedge pclk);
        check("rej_v_err", err, 1);
        check("rej_v_busy", busy, 0);
        tick();

        // timeout
        pulse_start(10, 10);
        n = 0;
        while (n < 300) begin
            @(negedge pclk);
            if (err) break;
            n++;
        end
        check("timeout_cycle", n, 100);
        check("timeout_busy", busy, 0);
        check("timeout_cap_en", cap_en, 1);
        tick();

        // mid-read reset
        nseen = 0;
        push_fetch(20, 30);
        out_ready = 1;
        pulse_start(20, 30);
        cap_pulse(1, "mr_cap_wait");
        cap_pulse(0, "mr_cap_drop");
        n = 0;
        while (nseen < 300 && n < 2000) begin
            tick();
            n++;
        end
        check("mr_reached_300", nseen >= 300, 1);
        rst = 1;
        tick();
        exp_q.delete();
        @(negedge pclk);
        check("mr_cap_en", cap_en, 1);
        check("mr_busy", busy, 0);
        check("mr_valid", out_valid, 0);
        check("mr_idx", int'(out_idx), 0);
        check("mr_raddr", int'(fb_raddr), 0);
        check("mr_done", done, 0);
        check("mr_err", err, 0);
        tick();
        rst = 0;
        tick();
        nseen = 0;
        push_fetch(50, 40);
        pulse_start(50, 40);
        cap_pulse(1, "mr2_cap_wait");
        cap_pulse(0, "mr2_cap_drop");
        wait_done(1000, 0);
        check("mr2_count", nseen, 784);

        // start coinciding with capture_end in IDLE
        push_fetch(0, 0);
        box_left = 0;
        box_up = 0;
        start = 1;
        capture_end = 1;
        tick();
        start = 0;
        capture_end = 0;
        cap_pulse(1, "co_cap_first");
        repeat (3) tick();
        @(negedge pclk);
        check("co_no_read", cap_en, 1);
        check("co_busy", busy, 1);
        tick();
        cap_pulse(0, "co_cap_drop");
        wait_done(1000, 0);

        repeat (3) tick();
        check("done_total", done_cnt, 4);
        check("err_total", err_cnt, 3);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/roi_fetch_ctrl.md
ROI_FETCH_CTRL -- requirements
Module: roi_fetch_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640: frame-buffer line pitch in pixels.
REQ-002 Parameter V_ACTIVE, default 480: frame height in lines.
REQ-003 Parameter OUT_DIM, default 28: output grid is OUT_DIM x OUT_DIM samples.
REQ-004 Parameter STEP, default 10: subsample stride in pixels and lines.
REQ-005 Parameter TIMEOUT_CYC, default 2000000: maximum cycles spent waiting for frames.
REQ-006 Port pclk, input, 1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: single-cycle request to fetch one ROI; ignored unless in IDLE.
REQ-009 Port capture_end, input, 1: end-of-frame pulse from the camera capture block.
REQ-010 Port box_left and box_up, input, 10 each: ROI origin, sampled on accepted start.
REQ-011 Port cap_en, output, 1: gates frame-buffer writes from the capture block.
REQ-012 Port fb_raddr, output, 19: frame-buffer read address.
REQ-013 Port fb_rdata, input, 8: read data, valid exactly one cycle after fb_raddr is issued.
REQ-014 Port out_ready, input, 1: consumer is able to accept a sample on the next cycle.
REQ-015 Ports out_valid (1), out_data (8), out_idx (10), outputs: output sample stream.
REQ-016 Ports busy, done, err, outputs, 1 each: status; done and err are single-cycle pulses.

Function
REQ-017 States: IDLE, ARM, WAIT_FRAME, READ, FLUSH, DONE.
REQ-018 IDLE: cap_en=1 and busy=0; start SHALL latch the box origin.
REQ-019 IDLE, range check: if box_left+(OUT_DIM-1)*STEP >= H_ACTIVE or box_up+(OUT_DIM-1)*STEP >= V_ACTIVE, then err pulses for one cycle and the block remains in IDLE.
REQ-020 IDLE, valid range: on start the block SHALL go to ARM.
REQ-021 ARM: cap_en=1 and busy=1; the first capture_end (which may end a partial frame) SHALL move the block to WAIT_FRAME.
REQ-022 WAIT_FRAME: cap_en=1; the next capture_end marks a complete frame, and on that cycle cap_en SHALL drop to 0 and the block SHALL enter READ.
REQ-023 Timeout: a cycle counter runs in ARM and WAIT_FRAME and is cleared on entering ARM; when it reaches TIMEOUT_CYC, err pulses and the block returns to IDLE with cap_en=1.
REQ-024 READ address: each cycle with out_ready=1 issues fb_raddr = row_base + col.
REQ-025 READ address generation: row_base starts at box_up*H_ACTIVE and col starts at box_left.
REQ-026 READ address update: col advances by STEP per sample; after OUT_DIM samples col reloads to box_left and row_base advances by STEP*H_ACTIVE.
REQ-027 READ, no multiplier: address arithmetic after setup SHALL use additions only, with a 19-bit unsigned result.
REQ-028 READ stall: when out_ready=0 no address is issued and the address counters hold.
REQ-029 Output timing: out_valid=1 exactly one cycle after each issued address, with out_data=fb_rdata and out_idx = issue order, 0..OUT_DIM*OUT_DIM-1.
REQ-030 READ to FLUSH: after issuing index OUT_DIM*OUT_DIM-1, the block SHALL go to FLUSH, in which no address is issued and the last out_valid appears.
REQ-031 FLUSH to DONE: the block SHALL go to DONE the cycle after FLUSH.
REQ-032 DONE: done pulses for one cycle, cap_en=1, and the block returns to IDLE.
REQ-033 cap_en SHALL be 0 from the transition into READ through FLUSH, inclusive.
REQ-034 Ignored inputs: start outside IDLE is ignored; capture_end in READ, FLUSH or DONE is ignored.
REQ-035 Simultaneous events in IDLE: if start and capture_end coincide, that capture_end SHALL NOT count toward ARM.
REQ-036 Idle outputs: fb_raddr holds its last value when no address is issued; out_data is don't-care when out_valid=0.

Reset
REQ-037 On rst the block SHALL enter IDLE and set cap_en=1, busy=0, done=0, err=0, out_valid=0, fb_raddr=0, out_data=0, out_idx=0, and clear all counters.
REQ-038 rst asserted mid-operation, in any state, SHALL abort the fetch with no done pulse, and the stream SHALL restart from index 0 on the next start.

Verification
REQ-039 Nominal fetch: box (180,100), start, two capture_end pulses, out_ready=1 -> cap_en falls on the second capture_end; 784 samples; first address 100*640+180=64180; second 64190; sample 28 at 70580; done pulses one cycle after the last out_valid.
REQ-040 Backpressure: out_ready toggles 1,0,1,0 during READ -> no address is repeated or skipped, out_idx runs 0..783 contiguously, and out_valid follows each issue by exactly one cycle.
REQ-041 Range reject: box_left=400 with start -> err pulses once, state stays IDLE, busy=0, and no fb_raddr activity.
REQ-042 Timeout: TIMEOUT_CYC=100, start, no capture_end -> err on cycle 100 after ARM entry, then IDLE with cap_en=1.
REQ-043 Mid-read reset: rst at sample 300 -> all outputs at reset values the next cycle; a subsequent fetch begins at out_idx 0 with no done pulse from the aborted fetch.
REQ-044 Coincident events: start and capture_end in the same cycle in IDLE -> two further capture_end pulses are required before READ.
